// File: rtl/vcve2_vec_pkg.sv
// Shared vector-unit types: element-width encoding, writeback FSM states and
// a byte-count helper for the element width.
package vcve2_vec_pkg;

    typedef enum logic [1:0] {
        SEW8     = 2'b00,
        SEW16    = 2'b01,
        SEW32    = 2'b10,
        SEW_RSVD = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } vwb_state_e;

    // Bytes occupied by one element; 0 for the reserved encoding.
    function automatic logic [2:0] sew_bytes(sew_e s);
        case (s)
            SEW8:    return 3'd1;
            SEW16:   return 3'd2;
            SEW32:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vcve2_vwb_block_if.sv
// Writeback stage bus: sequence control, execution result handshake and the
// register-file write port. master = upstream/environment, slave = the block.
interface vcve2_vwb_block_if #(
    parameter int ELEN = 32,
    parameter int VLEN = 128
);
    localparam int VLW = $clog2(VLEN) + 1;
    localparam int WW  = $clog2(VLEN / ELEN);

    logic             start_i;
    logic [4:0]       vd_i;
    logic [VLW-1:0]   vl_i;
    logic [1:0]       sew_i;
    logic             res_valid_i;
    logic             res_ready_o;
    logic [ELEN-1:0]  vec_result_ex_i;
    logic             vrf_we_o;
    logic [4:0]       vrf_waddr_o;
    logic [WW-1:0]    vrf_wword_o;
    logic [ELEN-1:0]  vrf_wdata_o;
    logic [ELEN/8-1:0] vrf_wbe_o;
    logic             busy_o;
    logic             done_o;
    logic             error_o;

    modport master (
        output start_i, vd_i, vl_i, sew_i, res_valid_i, vec_result_ex_i,
        input  res_ready_o, vrf_we_o, vrf_waddr_o, vrf_wword_o, vrf_wdata_o,
               vrf_wbe_o, busy_o, done_o, error_o
    );

    modport slave (
        input  start_i, vd_i, vl_i, sew_i, res_valid_i, vec_result_ex_i,
        output res_ready_o, vrf_we_o, vrf_waddr_o, vrf_wword_o, vrf_wdata_o,
               vrf_wbe_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/vcve2_vwb_block.sv
// Vector writeback: packs SEW-wide results into ELEN-wide words and writes
// them, byte-enabled, across an LMUL register group starting at vd.
module vcve2_vwb_block
    import vcve2_vec_pkg::*;
#(
    parameter int ELEN = 32,
    parameter int VLEN = 128,
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    vcve2_vwb_block_if.slave bus
);
    localparam int WPR = VLEN / ELEN;
    localparam int WW  = $clog2(WPR);
    localparam int VLW = $clog2(VLEN) + 1;
    localparam int NB  = ELEN / 8;

    // Lane arithmetic below is hard-wired for 32-bit words.
    if (ELEN != 32) begin : g_elen_chk
        $error("vcve2_vwb_block supports ELEN=32 only");
    end
    if (XLEN < ELEN) begin : g_xlen_chk
        $error("vcve2_vwb_block expects XLEN >= ELEN");
    end

    vwb_state_e      state;
    logic [4:0]      vd_q;
    logic [VLW-1:0]  vl_q;
    sew_e            sew_q;
    logic [VLW-1:0]  elem_cnt;
    logic [VLW-1:0]  word_idx;
    logic [ELEN-1:0] acc_q;
    logic [NB-1:0]   be_q;

    logic [1:0]      byte_off;
    logic [2:0]      nbytes;
    logic            last_lane;
    logic            last_elem;
    logic            accept;
    logic            wr_trig;
    logic [ELEN-1:0] acc_nx;
    logic [NB-1:0]   be_nx;

    assign accept    = bus.res_valid_i & (state == BUSY);
    assign last_elem = (elem_cnt == vl_q - 1'b1);
    assign wr_trig   = last_lane | last_elem;

    assign bus.res_ready_o = (state == BUSY);
    assign bus.busy_o      = (state != IDLE);

    // Lane position of the current element and its merge into the word.
    always_comb begin
        byte_off  = 2'd0;
        last_lane = 1'b1;
        acc_nx    = acc_q;
        be_nx     = be_q;
        nbytes    = sew_bytes(sew_q);
        case (sew_q)
            SEW8: begin
                byte_off  = elem_cnt[1:0];
                last_lane = &elem_cnt[1:0];
            end
            SEW16: begin
                byte_off  = {elem_cnt[0], 1'b0};
                last_lane = elem_cnt[0];
            end
            default: begin
                byte_off  = 2'd0;
                last_lane = 1'b1;
            end
        endcase
        for (int b = 0; b < NB; b++) begin
            if (b >= int'(byte_off) && b < int'(byte_off) + int'(nbytes)) begin
                acc_nx[8*b +: 8] = bus.vec_result_ex_i[8*(b - int'(byte_off)) +: 8];
                be_nx[b]         = 1'b1;
            end
        end
    end

    // Sequence FSM with registered write port and status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            vd_q            <= '0;
            vl_q            <= '0;
            sew_q           <= SEW8;
            elem_cnt        <= '0;
            word_idx        <= '0;
            acc_q           <= '0;
            be_q            <= '0;
            bus.vrf_we_o    <= 1'b0;
            bus.vrf_waddr_o <= '0;
            bus.vrf_wword_o <= '0;
            bus.vrf_wdata_o <= '0;
            bus.vrf_wbe_o   <= '0;
            bus.done_o      <= 1'b0;
            bus.error_o     <= 1'b0;
        end else begin
            bus.vrf_we_o    <= 1'b0;
            bus.vrf_wdata_o <= '0;
            bus.vrf_wbe_o   <= '0;
            bus.done_o      <= 1'b0;
            bus.error_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (sew_e'(bus.sew_i) == SEW_RSVD) begin
                            bus.error_o <= 1'b1;
                        end else if (bus.vl_i == '0) begin
                            state       <= DONE;
                            bus.done_o  <= 1'b1;
                        end else begin
                            state    <= BUSY;
                            vd_q     <= bus.vd_i;
                            vl_q     <= bus.vl_i;
                            sew_q    <= sew_e'(bus.sew_i);
                            elem_cnt <= '0;
                            word_idx <= '0;
                            acc_q    <= '0;
                            be_q     <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + 1'b1;
                        if (wr_trig) begin
                            bus.vrf_we_o    <= 1'b1;
                            bus.vrf_waddr_o <= vd_q + 5'(word_idx >> WW);
                            bus.vrf_wword_o <= word_idx[WW-1:0];
                            bus.vrf_wdata_o <= acc_nx;
                            bus.vrf_wbe_o   <= be_nx;
                            acc_q           <= '0;
                            be_q            <= '0;
                            word_idx        <= word_idx + 1'b1;
                        end else begin
                            acc_q <= acc_nx;
                            be_q  <= be_nx;
                        end
                        if (last_elem) begin
                            state      <= DONE;
                            bus.done_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vcve2_vwb_block.sv
// Bench for the vector writeback stage: directed sequences plus randomized
// ones, checked against a word-packing model built from the element list.
module tb_vcve2_vwb_block;
    import vcve2_vec_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vcve2_vwb_block_if #(.ELEN(32), .VLEN(128)) bus ();

    vcve2_vwb_block #(.ELEN(32), .VLEN(128), .XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [1:0]  w;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] elems [256];
    wr_t         exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected writes: element i lives in word i/EPW at byte (i%EPW)*SEW/8.
    task automatic build_model(input int vd, input int vl, input int sew);
        int sb, epw, nw, i;
        logic [31:0] m;
        wr_t e;
        sb  = 1 << sew;
        epw = 4 / sb;
        nw  = (vl + epw - 1) / epw;
        m   = (sb == 4) ? 32'hffff_ffff : ((32'd1 << (8*sb)) - 32'd1);
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            e.r  = 5'((vd + w / 4) % 32);
            e.w  = 2'(w % 4);
            e.d  = '0;
            e.be = '0;
            for (int j = 0; j < epw; j++) begin
                i = w * epw + j;
                if (i < vl) begin
                    e.d  = e.d | ((elems[i] & m) << (8*j*sb));
                    e.be = e.be | (4'(((1 << sb) - 1)) << (j*sb));
                end
            end
            exp_q.push_back(e);
        end
    endtask

    // mode: 0 back-to-back, 1 random gaps, 2 fixed gap pattern.
    task automatic run_seq(input int vd, input int vl, input int sew, input int mode,
                           input bit busy_start);
        int  k = 0;
        int  cyc = 0;
        int  pi = 0;
        bit  seen_done = 0;
        bit  v;
        bit  pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        wr_t got;
        build_model(vd, vl, sew);
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.vd_i        = 5'(vd);
        bus.vl_i        = 8'(vl);
        bus.sew_i       = 2'(sew);
        bus.res_valid_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        while (!seen_done && cyc < 500) begin
            if (bus.vrf_we_o) begin
                got = {bus.vrf_waddr_o, bus.vrf_wword_o, bus.vrf_wdata_o, bus.vrf_wbe_o};
                if (exp_q.size() == 0) check("extra_write", 64'(got), 64'd0);
                else check("write", 64'(got), 64'(exp_q.pop_front()));
            end else begin
                check("quiet_bus", {bus.vrf_wdata_o, bus.vrf_wbe_o}, 64'd0);
            end
            check("ready", bus.res_ready_o, (vl > 0 && k < vl));
            check("busy", bus.busy_o, 1);
            if (bus.done_o) begin
                seen_done = 1;
                check("done_count", k, vl);
                check("done_with_write", bus.vrf_we_o, (vl > 0));
                check("writes_left", exp_q.size(), 0);
            end
            // Start during BUSY/DONE with different fields must be ignored.
            bus.start_i = busy_start && !seen_done && (cyc == 2);
            if (bus.start_i) begin
                bus.vd_i  = 5'(vd ^ 5'h0a);
                bus.vl_i  = 8'(vl + 3);
                bus.sew_i = 2'((sew + 1) % 3);
            end
            if (k < vl && bus.res_ready_o) begin
                case (mode)
                    0:       v = 1;
                    1:       v = ($urandom_range(0, 2) != 0);
                    default: v = pat[pi % 7];
                endcase
                pi++;
                bus.res_valid_i     = v;
                bus.vec_result_ex_i = v ? elems[k] : $urandom;
                if (v) k++;
            end else begin
                bus.res_valid_i     = $urandom_range(0, 1) != 0;
                bus.vec_result_ex_i = $urandom;
            end
            cyc++;
            @(negedge clk);
        end
        bus.start_i     = 1'b0;
        bus.res_valid_i = 1'b0;
        if (!seen_done) check("done_timeout", 0, 1);
        check("idle_after", {bus.busy_o, bus.done_o, bus.vrf_we_o, bus.res_ready_o}, 0);
    endtask

    initial begin
        int vd, vl, sew;
        bus.start_i         = 1'b0;
        bus.vd_i            = '0;
        bus.vl_i            = '0;
        bus.sew_i           = '0;
        bus.res_valid_i     = 1'b0;
        bus.vec_result_ex_i = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_ctrl", {bus.busy_o, bus.done_o, bus.error_o, bus.res_ready_o, bus.vrf_we_o}, 0);
        check("reset_port", {bus.vrf_waddr_o, bus.vrf_wword_o, bus.vrf_wdata_o, bus.vrf_wbe_o}, 0);
        rst_n = 1'b1;

        // SEW32 vd=2 vl=4 back-to-back.
        for (int i = 0; i < 4; i++) elems[i] = 32'h1111_1111 * (i + 1);
        run_seq(2, 4, 2, 0, 0);

        // SEW8 vd=5 vl=6: full word then partial word with be=0011.
        for (int i = 0; i < 6; i++) elems[i] = 32'(i + 1);
        run_seq(5, 6, 0, 0, 0);

        // SEW16 vd=31 vl=10: register group wraps to reg0.
        for (int i = 0; i < 10; i++) elems[i] = $urandom;
        run_seq(31, 10, 1, 0, 0);

        // vl=0: immediate done, no writes.
        run_seq(7, 0, 0, 0, 0);

        // Reserved SEW: error pulse, stays idle.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.sew_i   = 2'b11;
        bus.vl_i    = 8'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("err_pulse", {bus.error_o, bus.busy_o, bus.res_ready_o}, 3'b100);
        @(negedge clk);
        check("err_clear", {bus.error_o, bus.busy_o}, 0);

        // SEW8 vl=4 with valid gaps and an ignored start while busy.
        for (int i = 0; i < 4; i++) elems[i] = 32'(i + 1);
        run_seq(9, 4, 0, 2, 1);

        // Reset mid-sequence after 3 accepted elements.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.vd_i    = 5'd3;
        bus.vl_i    = 8'd8;
        bus.sew_i   = 2'b00;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.res_valid_i     = 1'b1;
            bus.vec_result_ex_i = 32'(8'ha0 + i);
            @(negedge clk);
            check("pre_rst_no_write", bus.vrf_we_o, 0);
        end
        bus.res_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_rst", {bus.busy_o, bus.res_ready_o, bus.vrf_we_o, bus.done_o,
                                bus.vrf_wdata_o, bus.vrf_wbe_o}, 0);
        repeat (2) @(negedge clk);
        check("rst_held", {bus.vrf_we_o, bus.busy_o}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) elems[i] = $urandom;
        run_seq(3, 8, 0, 0, 0);

        // Randomized sequences with random gaps.
        for (int t = 0; t < 12; t++) begin
            vd  = $urandom_range(0, 31);
            sew = $urandom_range(0, 2);
            vl  = $urandom_range(0, 40);
            for (int i = 0; i < vl; i++) elems[i] = $urandom;
            run_seq(vd, vl, sew, 1, t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
